// File: rtl/ap_result_collector_pkg.sv
// ap_result_collector_pkg
//   Shared definitions for the AP result collector and the dot-product stage
//   that feeds it: FSM state encoding and the word/pad derivations, so both
//   sides agree on how many AP words a run produces.
package ap_result_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } collector_state_t;

    // Number of AP words needed to hold n results at u lanes per word.
    function automatic int unsigned calc_words(input int unsigned n, input int unsigned u);
        return (n + u - 1) / u;
    endfunction

    // Number of zero lanes in the final word.
    function automatic int unsigned calc_pad(input int unsigned n, input int unsigned u);
        return calc_words(n, u) * u - n;
    endfunction

endpackage

// File: rtl/ap_result_collector_packer.sv
// ap_lane_packer
//   Lane counter plus pack register. Each load writes data_in into the current
//   lane (lane 0 = most-significant slice) and advances the lane. Filling the
//   last lane returns the lane to 0 and clears the register; packed_next gives
//   the word including the element being loaded so the caller can register it.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   clear           synchronous clear of lane counter and pack register
//   load            write data_in into the current lane
//   data_in         element to pack
//   last_lane       current lane is the final lane of the word
//   packed_word     pack register contents (unfilled lanes are zero)
//   packed_next     pack register with data_in merged into the current lane
module ap_lane_packer #(
    parameter int unsigned element_width = 32,
    parameter int unsigned no_of_units   = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   clear,
    input  logic                                   load,
    input  logic [element_width-1:0]               data_in,
    output logic                                   last_lane,
    output logic [element_width*no_of_units-1:0]   packed_word,
    output logic [element_width*no_of_units-1:0]   packed_next
);

    localparam int unsigned lane_w = (no_of_units > 1) ? $clog2(no_of_units) : 1;

    logic [lane_w-1:0] lane;

    assign last_lane = (lane == lane_w'(no_of_units - 1));

    always_comb begin
        packed_next = packed_word;
        for (int unsigned k = 0; k < no_of_units; k++) begin
            if (lane == lane_w'(k)) begin
                packed_next[(no_of_units - k) * element_width - 1 -: element_width] = data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            lane        <= '0;
            packed_word <= '0;
        end else if (load) begin
            if (last_lane) begin
                lane        <= '0;
                packed_word <= '0;
            end else begin
                lane        <= lane + 1'b1;
                packed_word <= packed_next;
            end
        end
    end

endmodule

// File: rtl/ap_result_collector.sv
// ap_result_collector
//   Packs scalar dot-product results into no_of_units-lane words and writes
//   them to the AP vector memory starting at base_addr. The final word is
//   zero-padded when the result count is not a multiple of the lane count.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   start           one-cycle run request (ignored unless idle)
//   base_addr       first AP word address, latched on accepted start
//   result          scalar result, qualified by result_valid
//   result_valid    one-cycle qualifier for result
//   ap_mem_we       AP memory write enable, one cycle per word
//   ap_mem_addr     AP memory write address (wraps)
//   ap_mem_data     packed word, lane 0 in the most-significant slice
//   busy            high while collecting or flushing
//   done            one-cycle pulse after the final word write
//   overrun         sticky: result_valid seen while not collecting
module ap_result_collector
    import ap_result_collector_pkg::*;
#(
    parameter int unsigned number_of_equations_per_cluster = 16,
    parameter int unsigned element_width                   = 32,
    parameter int unsigned no_of_units                     = 8,
    parameter int unsigned addr_width                      = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [addr_width-1:0]                  base_addr,
    input  logic [element_width-1:0]               result,
    input  logic                                   result_valid,
    output logic                                   ap_mem_we,
    output logic [addr_width-1:0]                  ap_mem_addr,
    output logic [element_width*no_of_units-1:0]   ap_mem_data,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   overrun
);

    localparam int unsigned pad   = calc_pad(number_of_equations_per_cluster, no_of_units);
    localparam int unsigned cnt_w = $clog2(number_of_equations_per_cluster + 1);

    collector_state_t state, state_next;

    logic [addr_width-1:0]                base_q;
    logic [addr_width-1:0]                word_cnt;
    logic [cnt_w-1:0]                     elem_cnt;
    logic                                 last_lane;
    logic [element_width*no_of_units-1:0] packed_word;
    logic [element_width*no_of_units-1:0] packed_next;

    logic start_take;
    logic accept;
    logic lane_full;
    logic last_elem;

    assign start_take = (state == ST_IDLE) && start;
    assign accept     = (state == ST_COLLECT) && result_valid;
    assign lane_full  = accept && last_lane;
    assign last_elem  = accept && (elem_cnt == cnt_w'(number_of_equations_per_cluster - 1));
    assign busy       = (state == ST_COLLECT) || (state == ST_FLUSH);

    ap_lane_packer #(
        .element_width (element_width),
        .no_of_units   (no_of_units)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_take || (state == ST_FLUSH)),
        .load        (accept),
        .data_in     (result),
        .last_lane   (last_lane),
        .packed_word (packed_word),
        .packed_next (packed_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (start) state_next = ST_COLLECT;
            // With pad == 0 the last element also fills the last lane, so the
            // final word write is already registered and FLUSH is skipped.
            ST_COLLECT: if (last_elem) state_next = (pad == 0) ? ST_DONE : ST_FLUSH;
            ST_FLUSH:   state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ap_mem_we   <= 1'b0;
            ap_mem_addr <= '0;
            ap_mem_data <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            base_q      <= '0;
            word_cnt    <= '0;
            elem_cnt    <= '0;
        end else begin
            ap_mem_we <= 1'b0;
            // Registered from DONE so the pulse lands one cycle after the last write.
            done      <= (state == ST_DONE);

            if (start_take) begin
                base_q   <= base_addr;
                word_cnt <= '0;
                elem_cnt <= '0;
                overrun  <= 1'b0;
            end else if (result_valid && (state != ST_COLLECT)) begin
                overrun <= 1'b1;
            end

            if (accept) begin
                elem_cnt <= elem_cnt + 1'b1;
            end

            if (lane_full) begin
                ap_mem_we   <= 1'b1;
                ap_mem_addr <= base_q + word_cnt;
                ap_mem_data <= packed_next;
                word_cnt    <= word_cnt + 1'b1;
            end else if (state == ST_FLUSH) begin
                ap_mem_we   <= 1'b1;
                ap_mem_addr <= base_q + word_cnt;
                ap_mem_data <= packed_word;
                word_cnt    <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ap_result_collector.sv
module tb_ap_result_collector;

    localparam int unsigned W  = 32;
    localparam int unsigned U  = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = W * U;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic          start16, rv16, we16, busy16, done16, ovr16;
    logic [AW-1:0] base16, addr16;
    logic [W-1:0]  res16;
    logic [DW-1:0] data16;

    logic          start12, rv12, we12, busy12, done12, ovr12;
    logic [AW-1:0] base12, addr12;
    logic [W-1:0]  res12;
    logic [DW-1:0] data12;

    ap_result_collector #(
        .number_of_equations_per_cluster (16),
        .element_width                   (W),
        .no_of_units                     (U),
        .addr_width                      (AW)
    ) dut16 (
        .clk (clk), .reset (reset), .start (start16), .base_addr (base16),
        .result (res16), .result_valid (rv16), .ap_mem_we (we16),
        .ap_mem_addr (addr16), .ap_mem_data (data16), .busy (busy16),
        .done (done16), .overrun (ovr16)
    );

    ap_result_collector #(
        .number_of_equations_per_cluster (12),
        .element_width                   (W),
        .no_of_units                     (U),
        .addr_width                      (AW)
    ) dut12 (
        .clk (clk), .reset (reset), .start (start12), .base_addr (base12),
        .result (res12), .result_valid (rv12), .ap_mem_we (we12),
        .ap_mem_addr (addr12), .ap_mem_data (data12), .busy (busy12),
        .done (done12), .overrun (ovr12)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t sb16[$];
    wr_t sb12[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done16_cnt = 0, done16_cyc = -1, we16_cyc = -1;
    int done12_cnt = 0, done12_cyc = -1, we12_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element 0 lands in the most-significant slice; lanes past n are zero.
    function automatic logic [DW-1:0] mkword(input logic [W-1:0] first, input int n);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < int'(U); k++) begin
            w = w << W;
            if (k < n) w[W-1:0] = first + W'(k);
        end
        return w;
    endfunction

    wr_t e16, e12;

    always @(negedge clk) begin
        if (we16) begin
            check("wr16_expected", DW'(sb16.size() != 0), DW'(1));
            if (sb16.size() != 0) begin
                e16 = sb16.pop_front();
                check("wr16_addr", addr16, e16.addr);
                check("wr16_data", data16, e16.data);
                if (e16.cyc >= 0) check("wr16_cycle", DW'(cyc), DW'(e16.cyc));
            end
            we16_cyc = cyc;
        end
        if (done16) begin
            done16_cnt++;
            done16_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (we12) begin
            check("wr12_expected", DW'(sb12.size() != 0), DW'(1));
            if (sb12.size() != 0) begin
                e12 = sb12.pop_front();
                check("wr12_addr", addr12, e12.addr);
                check("wr12_data", data12, e12.data);
                if (e12.cyc >= 0) check("wr12_cycle", DW'(cyc), DW'(e12.cyc));
            end
            we12_cyc = cyc;
        end
        if (done12) begin
            done12_cnt++;
            done12_cyc = cyc;
        end
    end

    task automatic wait_done16(input int d0);
        for (int i = 0; i < 30 && done16_cnt == d0; i++) begin
            @(negedge clk);
            #1;
        end
        check("done16_pulse", DW'(done16_cnt), DW'(d0 + 1));
        check("done16_after_we", DW'(done16_cyc), DW'(we16_cyc + 1));
        check("sb16_drained", DW'(sb16.size()), DW'(0));
        check("busy16_end", busy16, DW'(0));
        check("ovr16_end", ovr16, DW'(0));
        @(negedge clk);
        check("done16_one_cycle", done16, DW'(0));
    endtask

    // Full back-to-back run of 16 results first..first+15.
    task automatic run16(input logic [AW-1:0] base, input logic [W-1:0] first,
                         input int mid_start, input bit start_rv);
        int d0;
        logic [AW-1:0] next_addr;
        d0 = done16_cnt;
        next_addr = base + 8'd1;
        start16 = 1'b1;
        base16  = base;
        if (start_rv) begin
            rv16  = 1'b1;
            res16 = 32'hDEAD_BEEF;
        end
        tick();
        start16 = 1'b0;
        rv16    = 1'b0;
        base16  = 8'hEE;
        @(negedge clk);
        check("busy16_after_start", busy16, DW'(1));
        check("ovr16_after_start", ovr16, DW'(0));
        tick();
        for (int i = 0; i < 16; i++) begin
            res16   = first + W'(i);
            rv16    = 1'b1;
            start16 = (i == mid_start);
            if (i == 7)  sb16.push_back('{base, mkword(first, 8), cyc + 1});
            if (i == 15) sb16.push_back('{next_addr, mkword(first + 32'd8, 8), cyc + 1});
            tick();
        end
        rv16    = 1'b0;
        start16 = 1'b0;
        wait_done16(d0);
    endtask

    initial begin
        int d0;
        reset   = 1'b0;
        start16 = 1'b0; rv16 = 1'b0; base16 = '0; res16 = '0;
        start12 = 1'b0; rv12 = 1'b0; base12 = '0; res12 = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_we16", we16, DW'(0));
        check("rst_done16", done16, DW'(0));
        check("rst_busy16", busy16, DW'(0));
        check("rst_ovr16", ovr16, DW'(0));
        check("rst_addr16", addr16, DW'(0));
        check("rst_data16", data16, DW'(0));
        check("rst_we12", we12, DW'(0));
        check("rst_busy12", busy12, DW'(0));
        tick();
        reset = 1'b1;
        tick();

        // Plain run, base 0x10.
        run16(8'h10, 32'd1, -1, 1'b0);

        // Stray result in IDLE sets overrun; the next start clears it, and a
        // start pulse at element 5 is ignored.
        rv16  = 1'b1;
        res16 = 32'h1234;
        tick();
        rv16 = 1'b0;
        @(negedge clk);
        check("ovr16_stray_idle", ovr16, DW'(1));
        check("busy16_stray_idle", busy16, DW'(0));
        tick();
        run16(8'h10, 32'd1, 4, 1'b0);

        // start and result_valid together: the result is dropped.
        run16(8'h30, 32'h300, -1, 1'b1);

        // Reset after element 10: no second write, outputs cleared.
        d0 = done16_cnt;
        start16 = 1'b1;
        base16  = 8'h40;
        tick();
        start16 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            res16 = 32'h400 + W'(i);
            rv16  = 1'b1;
            if (i == 7) sb16.push_back('{8'h40, mkword(32'h400, 8), cyc + 1});
            tick();
        end
        rv16  = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_we16", we16, DW'(0));
        check("midrst_done16", done16, DW'(0));
        check("midrst_busy16", busy16, DW'(0));
        check("midrst_ovr16", ovr16, DW'(0));
        check("midrst_addr16", addr16, DW'(0));
        check("midrst_data16", data16, DW'(0));
        repeat (20) tick();
        check("midrst_sb16_drained", DW'(sb16.size()), DW'(0));
        check("midrst_no_done", DW'(done16_cnt), DW'(d0));
        run16(8'h20, 32'h200, -1, 1'b0);

        // Address wrap.
        run16(8'hFF, 32'h500, -1, 1'b0);

        // N=12: random gaps, zero-padded final word via FLUSH.
        d0 = done12_cnt;
        start12 = 1'b1;
        base12  = 8'h00;
        tick();
        start12 = 1'b0;
        base12  = 8'h77;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            res12 = 32'hA1 + W'(i);
            rv12  = 1'b1;
            if (i == 7)  sb12.push_back('{8'h00, mkword(32'hA1, 8), cyc + 1});
            if (i == 11) sb12.push_back('{8'h01, mkword(32'hA9, 4), cyc + 2});
            tick();
            rv12 = 1'b0;
        end
        for (int i = 0; i < 30 && done12_cnt == d0; i++) begin
            @(negedge clk);
            #1;
        end
        check("done12_pulse", DW'(done12_cnt), DW'(d0 + 1));
        check("done12_after_we", DW'(done12_cyc), DW'(we12_cyc + 1));
        check("sb12_drained", DW'(sb12.size()), DW'(0));
        check("busy12_end", busy12, DW'(0));
        check("ovr12_end", ovr12, DW'(0));

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ap_result_collector.md
# ap_result_collector

Collects the scalar dot-product results produced by the vector-by-vector dot-product stage, one per matrix row. Packs them into `no_of_units`-lane words and writes each word to the AP vector memory. Zero-pads the final word when the equation count is not a multiple of the lane count. Sits directly downstream of the dot-product stage and produces the AP vector consumed by the next solver iteration.

## Interface
Parameters:
- `number_of_equations_per_cluster`, 16, number of scalar results (rows) per run.
- `element_width`, 32, width of one result.
- `no_of_units`, 8, lanes per AP memory word.
- `addr_width`, 8, AP memory address width.
- Derived, not overridable:
  - `words` = ceil(`number_of_equations_per_cluster` / `no_of_units`).
  - `pad` = `words`*`no_of_units` − `number_of_equations_per_cluster`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low; `reset`==0 resets the block at the next rising edge.
- `start`  in  1  one-cycle request to begin a run.
- `base_addr`  in  `addr_width`  first AP word address; latched on accepted `start`.
- `result`  in  `element_width`  scalar dot-product result.
- `result_valid`  in  1  one-cycle qualifier for `result` (the dot-product `finish` pulse).
- `ap_mem_we`  out  1  AP memory write enable, one cycle per word.
- `ap_mem_addr`  out  `addr_width`  write address.
- `ap_mem_data`  out  `element_width*no_of_units`  packed word.
- `busy`  out  1  high in COLLECT and FLUSH.
- `done`  out  1  one-cycle pulse after the final word write.
- `overrun`  out  1  sticky: `result_valid` arrived while not collecting.

## Operation
- Reset values: all outputs 0; state IDLE; lane, word and element counters 0; pack register 0.
- States: IDLE, COLLECT, FLUSH, DONE.
- IDLE:
  - On `start`: latch `base_addr`, clear counters, pack register and `overrun`, then go to COLLECT.
  - `result_valid` without `start` sets `overrun`.
  - `start` and `result_valid` in the same cycle: `start` is taken, the result is dropped, and `overrun` is not set.
- COLLECT:
  - Each `result_valid` writes `result` into lane index `lane` and increments the element counter.
  - Lane 0 is the most-significant slice, `[no_of_units*element_width-1 -: element_width]`; element k of the word sits at `[(no_of_units-k)*element_width-1 -: element_width]`.
  - When lane `no_of_units-1` is filled, register a word write:
    - `ap_mem_data` = packed word, `ap_mem_addr` = base + word counter, `ap_mem_we`=1;
    - word counter +1; lane returns to 0; pack register clears.
  - After element `number_of_equations_per_cluster` is accepted:
    - if `pad`==0, that same write is the last one; go to DONE;
    - otherwise go to FLUSH.
- FLUSH: write the partial word with the remaining `pad` low lanes = 0, then go to DONE. Any `result_valid` here sets `overrun` and is dropped.
- DONE: `done`=1 for one cycle, then IDLE. `result_valid` here sets `overrun`.
- `start` while `busy` is ignored.
- Stray inputs outside COLLECT: `result` is never written outside COLLECT, and no memory write occurs.
- Address arithmetic wraps modulo 2^`addr_width`.

## Timing
- Word write latency: `ap_mem_we` is high in the cycle after the edge that captured the word's last lane. It lasts exactly one cycle, with data and address stable during it.
- FLUSH write: `ap_mem_we` is high in the cycle after entering FLUSH.
- `done` follows the last `ap_mem_we` by one cycle.
- `busy` rises in the cycle after an accepted `start` and falls when DONE is entered.
- `result_valid` may arrive every cycle with no gaps; full throughput, no backpressure.
- Reset mid-run:
  - the partial word is discarded and no write is issued;
  - `ap_mem_we`, `done` and `busy` are 0 in the cycle after the reset edge.

## Structure
- Shared package: the state encoding (IDLE/COLLECT/FLUSH/DONE), and the functions deriving `words` and `pad` from the parameters, so the dot-product stage and the collector agree.
- One natural sub-module, `ap_lane_packer`: lane counter plus pack register with a clear input. The FSM and address counter stay in the top.

## Test plan
- N=16, U=8, base=0x10; start, then results 1..16 back-to-back → writes at 0x10 and 0x11:
  - word0 lanes MSB→LSB = 1..8, word1 = 9..16;
  - `done` one cycle after the second write; `overrun`=0.
- N=12, U=8, base=0; results 0xA1..0xAC with random gaps → word0 = 0xA1..0xA8, word1 = 0xA9..0xAC followed by four zero lanes; `done` follows.
- `result_valid` in IDLE, then `start` → `overrun`=1, then cleared by `start`; `start`+`result_valid` in the same cycle → `overrun` stays 0 and the first collected element is the next valid.
- `start` pulsed mid-run at element 5 → ignored; addresses and data identical to the first scenario.
- `reset`=0 after element 10 of N=16 → no second write, all outputs 0. A new run from base 0x20 then writes correctly at 0x20/0x21.
- base=0xFF, N=16 → second write at address 0x00 (wrap).
